multiply: RTL and testbench

Sequential shift-add multiplier, companion to the existing iterative divider in the 64-bit ALU datapath. Takes two WIDTH-bit operands, unsigned or two's-complement per `sign`, and produces the full 2·WIDTH-bit product over WIDTH clock cycles, one partial product per cycle. Uses the same ready/busy behaviour as the divider, plus an explicit `start` strobe, so the ALU control can sequence both units the same way.

---
 rtl/multiply_pkg.sv | 16 +
 rtl/multiply_twos_mag.sv | 16 +
 rtl/multiply.sv | 96 +++++++++
 tb/tb_multiply.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/multiply_pkg.sv
// Shared ALU definitions for the multiplier: default operand width and the
// control state encoding shared with the divider's control wrapper.
package multiply_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/multiply_twos_mag.sv
// twos_mag helper: magnitude of a possibly two's-complement value plus its
// negative flag. With NEG_ALWAYS set, sign alone requests negation (result negator).
module multiply_twos_mag #(
  parameter int WIDTH      = 32,
  parameter bit NEG_ALWAYS = 1'b0
) (
  input  logic [WIDTH-1:0] value,
  input  logic             sign,
  output logic [WIDTH-1:0] mag,
  output logic             neg
);

  assign neg = sign & (NEG_ALWAYS | value[WIDTH-1]);
  assign mag = neg ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/multiply.sv
// Sequential shift-add multiplier: one partial product per cycle, full
// 2*WIDTH-bit signed/unsigned product after WIDTH cycles.
module multiply
  import multiply_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sign,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ready
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand_copy;
  logic [WIDTH-1:0]   mplier_copy;
  logic               negative_output;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               a_neg;
  logic               b_neg;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] res_mag;
  logic               res_neg;

  multiply_twos_mag #(.WIDTH(WIDTH)) u_mag_a (
    .value (multiplicand),
    .sign  (sign),
    .mag   (a_mag),
    .neg   (a_neg)
  );

  multiply_twos_mag #(.WIDTH(WIDTH)) u_mag_b (
    .value (multiplier),
    .sign  (sign),
    .mag   (b_mag),
    .neg   (b_neg)
  );

  // Result negator: negates whenever the captured operand signs differ.
  multiply_twos_mag #(.WIDTH(2*WIDTH), .NEG_ALWAYS(1'b1)) u_neg_res (
    .value (acc_next),
    .sign  (negative_output),
    .mag   (res_mag),
    .neg   (res_neg)
  );

  assign acc_next = mplier_copy[0] ? (acc + mcand_copy) : acc;
  assign ready    = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      count           <= '0;
      acc             <= '0;
      mcand_copy      <= '0;
      mplier_copy     <= '0;
      negative_output <= 1'b0;
      product         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand_copy      <= {{WIDTH{1'b0}}, a_mag};
            mplier_copy     <= b_mag;
            acc             <= '0;
            count           <= CW'(WIDTH);
            negative_output <= a_neg ^ b_neg;
            state           <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc         <= acc_next;
          mcand_copy  <= mcand_copy << 1;
          mplier_copy <= mplier_copy >> 1;
          count       <= count - CW'(1);
          if (count == CW'(1)) begin
            product <= res_neg ? res_mag : acc_next;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiply.sv
// Directed checks for the shift-add multiplier: reset, unsigned/signed
// products, latency, handshake, mid-operation reset and a short random sweep.
module tb_multiply;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           sign = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic [2*W-1:0] product;
  logic           ready;

  int errors = 0;
  int checks = 0;

  multiply #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sign         (sign),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for ready; operands are scrambled
  // right after the capture edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [2*W-1:0] prod, output int cycles, output logic accepted);
    @(negedge clk);
    start = 1'b1; sign = s; multiplicand = a; multiplier = b;
    @(posedge clk); #1;
    accepted = !ready;
    start = 1'b0; multiplicand = $urandom; multiplier = $urandom; sign = ~s;
    cycles = 0;
    while (!ready && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    prod = product;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++;
    if (product !== 64'h0) begin errors++; $display("FAIL reset_product got=%h exp=0", product); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [2*W-1:0] p; int cyc; logic acc_ok;
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, p, cyc, acc_ok);
    checks++;
    if (acc_ok !== 1'b1) begin errors++; $display("FAIL uns_accept got=%b exp=1", acc_ok); end
    checks++;
    if (p !== 64'hFFFFFFFE00000001) begin errors++; $display("FAIL uns_max got=%h exp=fffffffe00000001", p); end
    checks++;
    if (cyc != 32) begin errors++; $display("FAIL uns_latency got=%0d exp=32", cyc); end
    run_op(32'h80000000, 32'h00000001, 1'b0, p, cyc, acc_ok);
    checks++;
    if (p !== 64'h0000000080000000) begin errors++; $display("FAIL uns_msb got=%h exp=0000000080000000", p); end
    run_op(32'd12345, 32'd6789, 1'b0, p, cyc, acc_ok);
    checks++;
    if (p !== 64'd83810205) begin errors++; $display("FAIL uns_small got=%h exp=%h", p, 64'd83810205); end
  endtask

  task automatic test_signed();
    logic [2*W-1:0] p; int cyc; logic acc_ok;
    run_op(32'h80000000, 32'h00000001, 1'b1, p, cyc, acc_ok);
    checks++;
    if (p !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL sgn_minxone got=%h exp=ffffffff80000000", p); end
    run_op(32'hFFFFFFFD, 32'd7, 1'b1, p, cyc, acc_ok);
    checks++;
    if (p !== 64'hFFFFFFFFFFFFFFEB) begin errors++; $display("FAIL sgn_m3x7 got=%h exp=ffffffffffffffeb", p); end
    run_op(32'hFFFFFFFD, 32'hFFFFFFF9, 1'b1, p, cyc, acc_ok);
    checks++;
    if (p !== 64'd21) begin errors++; $display("FAIL sgn_negneg got=%h exp=15", p); end
  endtask

  task automatic test_extremes();
    logic [2*W-1:0] p; int cyc; logic acc_ok;
    run_op(32'h80000000, 32'h80000000, 1'b1, p, cyc, acc_ok);
    checks++;
    if (p !== 64'h4000000000000000) begin errors++; $display("FAIL sgn_minxmin got=%h exp=4000000000000000", p); end
    run_op(32'h0, 32'hFFFFFFFB, 1'b1, p, cyc, acc_ok);
    checks++;
    if (p !== 64'h0) begin errors++; $display("FAIL zero_neg got=%h exp=0", p); end
    checks++;
    if (cyc != 32) begin errors++; $display("FAIL zero_latency got=%0d exp=32", cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc; int unstable;
    @(negedge clk);
    start = 1'b1; sign = 1'b0; multiplicand = 32'd3; multiplier = 32'd5;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got=%b exp=0", ready); end
    multiplicand = 32'd9; multiplier = 32'd9;   // start stays high through BUSY
    cyc = 0;
    while (!ready && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (product !== 64'd15) begin errors++; $display("FAIL b2b_first got=%h exp=f", product); end
    checks++;
    if (cyc != 32) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=32", cyc); end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept got=%b exp=0", ready); end
    cyc = 0; unstable = 0;
    while (!ready && cyc < 100) begin
      if (product !== 64'd15) unstable++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL b2b_hold got=%0d changes exp=0", unstable); end
    checks++;
    if (product !== 64'd81) begin errors++; $display("FAIL b2b_second got=%h exp=51", product); end
    checks++;
    if (cyc != 32) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=32", cyc); end
  endtask

  task automatic test_reset_mid();
    logic [2*W-1:0] p; int cyc; logic acc_ok;
    @(negedge clk);
    start = 1'b1; sign = 1'b0; multiplicand = 32'h1234; multiplier = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", ready); end
    checks++;
    if (product !== 64'h0) begin errors++; $display("FAIL midrst_product got=%h exp=0", product); end
    @(negedge clk);
    rst = 1'b0;
    run_op(32'd6, 32'd7, 1'b0, p, cyc, acc_ok);
    checks++;
    if (p !== 64'd42) begin errors++; $display("FAIL midrst_after got=%h exp=2a", p); end
  endtask

  task automatic test_random();
    logic [2*W-1:0] p; logic [2*W-1:0] exp_p; int cyc; logic acc_ok;
    logic [W-1:0] a; logic [W-1:0] b; logic s;
    int bad = 0;
    for (int i = 0; i < 100; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      if (i % 10 == 0) a = 32'h80000000;
      if (s) exp_p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      else   exp_p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      run_op(a, b, s, p, cyc, acc_ok);
      if (p !== exp_p || cyc != 32) begin
        bad++;
        $display("FAIL random a=%h b=%h s=%b got=%h exp=%h cycles=%0d", a, b, s, p, exp_p, cyc);
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL random_sweep got=%0d bad exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
